// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and layer indices for the CNN inference pipeline.
// Layer order is fixed: conv1, pool1, conv2, pool2, fc.
package cnn_pkg;

  localparam int NUM_LAYERS = 5;

  localparam int STG_CONV1 = 0;
  localparam int STG_POOL1 = 1;
  localparam int STG_CONV2 = 2;
  localparam int STG_POOL2 = 3;
  localparam int STG_FC    = 4;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LAUNCH,
    WAIT,
    FINISH,
    ERR
  } seq_state_t;

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// stage_watchdog: counts cycles spent waiting on one engine and flags
// the cycle in which the count reaches limit-1; limit 0 disables it.
module stage_watchdog #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable
                && (limit != '0)
                && (cnt == limit - 1'b1);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: walks the layer chain, launching each enabled
// engine in turn and guarding every wait with a watchdog.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int NUM_STAGES = NUM_LAYERS,
  parameter int TIMEOUT_W  = 20,
  parameter int CYC_W      = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_en,
  input  logic [TIMEOUT_W-1:0]  timeout_lim,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [2:0]            cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_stage,
  output logic [CYC_W-1:0]      total_cycles
);

  seq_state_t state_q, state_d;

  logic [NUM_STAGES-1:0] en_q;
  logic [2:0]            cur_q, cur_d;
  logic [2:0]            sel_idx;
  logic                  sel_found;
  logic                  accept;
  logic                  timeout;
  logic                  wd_expired;
  logic                  cur_done;

  assign accept   = (state_q == IDLE) && start;
  assign cur_done = stage_done[cur_q];

  stage_watchdog #(
    .W(TIMEOUT_W)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == LAUNCH),
    .enable (state_q == WAIT),
    .limit  (timeout_lim),
    .expired(wd_expired)
  );

  // Lowest enabled stage at or above cur_q; indices past the
  // last stage never match, which reads as "none left".
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= int'(cur_q) && en_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    timeout = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cur_d   = '0;
            state_d = SELECT;
          end
        end
        SELECT: begin
          if (sel_found) begin
            cur_d   = sel_idx;
            state_d = LAUNCH;
          end else begin
            state_d = FINISH;
          end
        end
        LAUNCH: state_d = WAIT;
        WAIT: begin
          if (cur_done) begin
            cur_d   = cur_q + 1'b1;
            state_d = SELECT;
          end else if (wd_expired) begin
            timeout = 1'b1;
            state_d = ERR;
          end
        end
        FINISH:  state_d = IDLE;
        ERR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      en_q         <= '0;
      error        <= 1'b0;
      err_stage    <= '0;
      total_cycles <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (accept) begin
        en_q         <= stage_en;
        error        <= 1'b0;
        err_stage    <= '0;
        total_cycles <= '0;
      end else begin
        if (timeout) begin
          error     <= 1'b1;
          err_stage <= cur_q;
        end
        if (busy && total_cycles != '1) begin
          total_cycles <= total_cycles + 1'b1;
        end
      end
    end
  end

  // An abort in the same cycle suppresses the launch and the done pulse.
  always_comb begin
    stage_start = '0;
    if (state_q == LAUNCH && !abort) begin
      stage_start[cur_q] = 1'b1;
    end
  end

  assign busy      = (state_q == SELECT)
                  || (state_q == LAUNCH)
                  || (state_q == WAIT);
  assign done      = (state_q == FINISH) && !abort;
  assign cur_stage = cur_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed passes through the layer sequencer
// with a small engine model answering each start after a set latency.
module tb_cnn_layer_sequencer;
  import cnn_pkg::*;

  localparam int NS = NUM_LAYERS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [NS-1:0] stage_en;
  logic [19:0]   timeout_lim;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] stage_start;
  logic [2:0]    cur_stage;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    err_stage;
  logic [23:0]   total_cycles;

  cnn_layer_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .stage_en    (stage_en),
    .timeout_lim (timeout_lim),
    .stage_done  (stage_done),
    .stage_start (stage_start),
    .cur_stage   (cur_stage),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_stage   (err_stage),
    .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          lat [NS];
  int          lc  [NS];
  int          abort_c = -1;
  int          stray_c = -1;
  logic [NS-1:0] stray_m = '0;
  logic        hold = 1'b0;

  int   q_start[$];
  int   n_done;
  int   done_c;
  int   err_c;
  int   n_multi;
  logic busy_err;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start order as decimal digits of (index+1), e.g. {1,3} -> 24.
  function automatic int seq_code();
    int s = 0;
    foreach (q_start[i]) s = s * 10 + q_start[i] + 1;
    return s;
  endfunction

  task automatic go(input logic [NS-1:0] m);
    stage_en = m;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = hold;
  endtask

  // Cycle 0 is the first cycle after the accepting edge.
  task automatic run(input int budget);
    q_start.delete();
    n_done   = 0;
    done_c   = -1;
    err_c    = -1;
    n_multi  = 0;
    busy_err = 1'bx;
    for (int i = 0; i < NS; i++) lc[i] = -100;
    for (int c = 0; c < budget; c++) begin
      if ($countones(stage_start) > 1) n_multi++;
      for (int i = 0; i < NS; i++) begin
        if (stage_start[i]) begin
          q_start.push_back(i);
          lc[i] = c;
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (error === 1'b1 && err_c < 0) begin
        err_c    = c;
        busy_err = busy;
      end
      for (int i = 0; i < NS; i++) begin
        stage_done[i] = lat[i] > 0 && c == lc[i] + lat[i];
      end
      if (c == stray_c) stage_done = stage_done | stray_m;
      abort = (c == abort_c);
      start = hold && n_done == 0;
      @(posedge clk);
      @(negedge clk);
    end
    stage_done = '0;
    abort      = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    stage_en    = '0;
    stage_done  = '0;
    timeout_lim = '0;
    for (int i = 0; i < NS; i++) lat[i] = 3;
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", stage_start, 0);
    chk("rst_cur", cur_stage, 0);
    chk("rst_error", error, 0);
    chk("rst_errstg", err_stage, 0);
    chk("rst_total", total_cycles, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full chain: 5 x (SELECT+LAUNCH+3 WAIT) + final SELECT busy cycles.
    go(5'b11111);
    run(32);
    chk("t1_order", seq_code(), 12345);
    chk("t1_ndone", n_done, 1);
    chk("t1_done_c", done_c, 26);
    chk("t1_total", total_cycles, 26);
    chk("t1_onehot", n_multi, 0);
    chk("t1_busy", busy, 0);

    // Mask latched at accept; later stage_en changes are ignored.
    go(5'b01010);
    stage_en = 5'b10101;
    run(16);
    chk("t2_order", seq_code(), 24);
    chk("t2_done_c", done_c, 11);
    chk("t2_total", total_cycles, 11);

    // Stage 2 hangs; 8 WAIT cycles then ERR.
    timeout_lim = 20'd8;
    lat[STG_CONV2] = 0;
    go(5'b11111);
    run(24);
    chk("t3_order", seq_code(), 123);
    chk("t3_err_c", err_c, 20);
    chk("t3_busy_err", busy_err, 0);
    chk("t3_ndone", n_done, 0);
    chk("t3_error", error, 1);
    chk("t3_errstg", err_stage, 2);
    chk("t3_total", total_cycles, 20);
    lat[STG_CONV2] = 3;
    timeout_lim = '0;
    go(5'b00001);
    chk("t3_clear", error, 0);
    run(10);
    chk("t3_rerun_done", done_c, 6);

    // Done and timeout in the same WAIT cycle: done wins.
    timeout_lim = 20'd3;
    go(5'b10000);
    run(10);
    chk("tie_error", error, 0);
    chk("tie_done_c", done_c, 6);
    chk("tie_order", seq_code(), 5);
    lat[STG_FC] = 4;
    go(5'b10000);
    run(10);
    chk("wd3_err_c", err_c, 5);
    chk("wd3_errstg", err_stage, 4);
    chk("wd3_ndone", n_done, 0);
    lat[STG_FC] = 3;
    timeout_lim = '0;

    // Abort beats stage_done[1] in its last WAIT cycle.
    abort_c = 9;
    go(5'b11111);
    run(20);
    abort_c = -1;
    chk("t4_order", seq_code(), 12);
    chk("t4_ndone", n_done, 0);
    chk("t4_error", error, 0);
    chk("t4_busy", busy, 0);
    chk("t4_total", total_cycles, 10);

    // Start held through the pass and a stray done from stage 4.
    hold    = 1'b1;
    stray_c = 3;
    stray_m = 5'b10000;
    go(5'b11111);
    run(32);
    hold    = 1'b0;
    stray_c = -1;
    chk("t5_order", seq_code(), 12345);
    chk("t5_ndone", n_done, 1);
    chk("t5_done_c", done_c, 26);

    // Async reset between edges during stage 1 WAIT.
    go(5'b11111);
    run(8);
    chk("t6_pre_cur", cur_stage, 1);
    chk("t6_pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cur", cur_stage, 0);
    chk("t6_total", total_cycles, 0);
    chk("t6_start", stage_start, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    go(5'b00000);
    run(5);
    chk("t6_skip_done_c", done_c, 1);
    chk("t6_skip_ndone", n_done, 1);
    chk("t6_skip_order", seq_code(), 0);
    chk("t6_skip_total", total_cycles, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
